stack_arbiter: RTL

- Shares one Stack instance (push/pop/data_in/data_out/stack_empty/stack_full) between NUM_REQ independent requesters.
- Round-robin arbitration; one stack operation in flight at a time.
- Rejects push-on-full and pop-on-empty without touching the stack, and returns popped data to the winning requester.
- Sits directly in front of the Stack; the controller is the sole driver of the Stack's push, pop and data_in.

---
 rtl/stack_arb_pkg.sv | 22 ++
 rtl/stack_arbiter_rr.sv | 39 +++
 rtl/stack_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/stack_arb_pkg.sv
// Shared definitions for the stack arbiter slice.
// Holds the controller state encoding, the push/pop opcode values, the
// width of the rejected-request counter and a saturating increment helper.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OP_PUSH   = 1'b0;
  localparam logic OP_POP    = 1'b1;
  localparam int   ERR_CNT_W = 8;

  // Counter that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ERR_CNT_W-1:0] satInc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr.sv
// Round-robin arbiter, purely combinational and reusable.
// Searches upward from i_ptr+1 (wrapping) for the first set request.
// Ports:
//   i_req   : request vector, one bit per requester
//   i_ptr   : index of the requester granted last
//   o_grant : one-hot grant
//   o_idx   : encoded grant index
//   o_valid : at least one request is set
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Offsets 1..NUM_REQ cover every requester once, the last offset being the
  // previous winner itself, so it only wins again when nobody else asks.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares a single Stack between NUM_REQ requesters with round-robin
// arbitration and one stack operation in flight at a time. Push-on-full and
// pop-on-empty are rejected without strobing the stack.
// Ports:
//   clk, reset          : clock (rising edge), async active-low reset
//   req/req_op/req_data : per-requester request, op (0 push, 1 pop), data
//   ack/ack_err         : one-cycle completion pulse and reject flag
//   rsp_data            : popped data, valid with ack on a good pop
//   grant_idx, busy     : requester being served, controller not idle
//   err_cnt             : saturating count of rejected requests
//   stk_*               : connection to the Stack (strobes, data, flags)
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      ack_err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [DATA_W-1:0]         stk_data_in,
  input  logic [DATA_W-1:0]         stk_data_out,
  input  logic                      stk_empty,
  input  logic                      stk_full
);

  state_t               r_state, w_next_state;
  logic [IDX_W-1:0]     r_ptr, w_next_ptr;
  logic                 r_op, w_next_op;
  logic [DATA_W-1:0]    r_data, w_next_data;
  logic [NUM_REQ-1:0]   r_grant_oh, w_next_grant_oh;
  logic [NUM_REQ-1:0]   r_ack, w_next_ack;
  logic                 r_ack_err, w_next_ack_err;
  logic [DATA_W-1:0]    r_rsp_data, w_next_rsp_data;
  logic [IDX_W-1:0]     r_grant_idx, w_next_grant_idx;
  logic                 r_busy, w_next_busy;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_next_err_cnt;
  logic                 r_stk_push, w_next_stk_push;
  logic                 r_stk_pop, w_next_stk_pop;
  logic [DATA_W-1:0]    r_stk_data_in, w_next_stk_data_in;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_valid;
  logic                 w_op;
  logic [DATA_W-1:0]    w_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_op   = req_op[w_idx];
  assign w_data = req_data[int'(w_idx)*DATA_W +: DATA_W];

  // Every output is a register, so the next values are computed for the
  // state being entered: a strobe or ack lands in the cycle the FSM sits in
  // ISSUE or RESP respectively.
  always_comb begin
    w_next_state       = r_state;
    w_next_ptr         = r_ptr;
    w_next_op          = r_op;
    w_next_data        = r_data;
    w_next_grant_oh    = r_grant_oh;
    w_next_grant_idx   = r_grant_idx;
    w_next_ack         = '0;
    w_next_ack_err     = 1'b0;
    w_next_rsp_data    = r_rsp_data;
    w_next_err_cnt     = r_err_cnt;
    w_next_stk_push    = 1'b0;
    w_next_stk_pop     = 1'b0;
    w_next_stk_data_in = '0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_next_ptr       = w_idx;
          w_next_op        = w_op;
          w_next_data      = w_data;
          w_next_grant_oh  = w_grant;
          w_next_grant_idx = w_idx;
          // Rejects skip the stack entirely and answer on the next cycle.
          if ((w_op == OP_PUSH && stk_full) || (w_op == OP_POP && stk_empty)) begin
            w_next_state    = RESP;
            w_next_ack      = w_grant;
            w_next_ack_err  = 1'b1;
            w_next_rsp_data = '0;
            w_next_err_cnt  = satInc(r_err_cnt);
          end else begin
            w_next_state       = ISSUE;
            w_next_stk_push    = (w_op == OP_PUSH);
            w_next_stk_pop     = (w_op == OP_POP);
            w_next_stk_data_in = (w_op == OP_PUSH) ? w_data : '0;
          end
        end
      end
      ISSUE: begin
        if (r_op == OP_PUSH) begin
          w_next_state = RESP;
          w_next_ack   = r_grant_oh;
        end else begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_next_state    = RESP;
        w_next_ack      = r_grant_oh;
        w_next_rsp_data = stk_data_out;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    w_next_busy = (w_next_state != IDLE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_ptr         <= IDX_W'(NUM_REQ - 1);
      r_op          <= OP_PUSH;
      r_data        <= '0;
      r_grant_oh    <= '0;
      r_grant_idx   <= '0;
      r_ack         <= '0;
      r_ack_err     <= 1'b0;
      r_rsp_data    <= '0;
      r_busy        <= 1'b0;
      r_err_cnt     <= '0;
      r_stk_push    <= 1'b0;
      r_stk_pop     <= 1'b0;
      r_stk_data_in <= '0;
    end else begin
      r_state       <= w_next_state;
      r_ptr         <= w_next_ptr;
      r_op          <= w_next_op;
      r_data        <= w_next_data;
      r_grant_oh    <= w_next_grant_oh;
      r_grant_idx   <= w_next_grant_idx;
      r_ack         <= w_next_ack;
      r_ack_err     <= w_next_ack_err;
      r_rsp_data    <= w_next_rsp_data;
      r_busy        <= w_next_busy;
      r_err_cnt     <= w_next_err_cnt;
      r_stk_push    <= w_next_stk_push;
      r_stk_pop     <= w_next_stk_pop;
      r_stk_data_in <= w_next_stk_data_in;
    end
  end

  assign ack         = r_ack;
  assign ack_err     = r_ack_err;
  assign rsp_data    = r_rsp_data;
  assign grant_idx   = r_grant_idx;
  assign busy        = r_busy;
  assign err_cnt     = r_err_cnt;
  assign stk_push    = r_stk_push;
  assign stk_pop     = r_stk_pop;
  assign stk_data_in = r_stk_data_in;

endmodule
